// File: rtl/lif_tdm_scheduler_if.sv
// lif_tdm_scheduler_if
//   Bundles the requester-facing signals of the LIF time-multiplexed scheduler.
//   master : requester side (drives req/cur, observes results)
//   slave  : scheduler side (observes req/cur, drives results)
//   Signals:
//     req         per-neuron level request, held with cur stable until ack
//     cur         packed 8-bit unsigned currents, neuron i at [8i+7:8i]
//     ack         one-hot, one-cycle completion pulse
//     spike_valid one-cycle pulse with ack when the completed update fired
//     spike_id    index of the neuron reported by ack/spike
//     state_out   post-update membrane state of spike_id
//     busy        scheduler is mid-update
interface lif_tdm_scheduler_if #(
  parameter int N_NEUR = 4
) ();
  localparam int ID_W = $clog2(N_NEUR);

  logic [N_NEUR-1:0]   req;
  logic [8*N_NEUR-1:0] cur;
  logic [N_NEUR-1:0]   ack;
  logic                spike_valid;
  logic [ID_W-1:0]     spike_id;
  logic [7:0]          state_out;
  logic                busy;

  modport master (
    output req, cur,
    input  ack, spike_valid, spike_id, state_out, busy
  );

  modport slave (
    input  req, cur,
    output ack, spike_valid, spike_id, state_out, busy
  );
endinterface

// File: rtl/lif_tdm_scheduler.sv
// lif_tdm_scheduler
//   Shares one leaky-integrate-and-fire update datapath among N_NEUR virtual
//   neurons. Requesters are granted round-robin; each grant runs
//   IDLE -> CALC -> WRITE and reports its result as a one-cycle ack pulse.
//   Ports:
//     clk  rising-edge clock
//     rst  synchronous active-high reset
//     bus  lif_tdm_scheduler_if.slave (req/cur in; ack/spike/state/busy out)
//   Parameters:
//     N_NEUR      number of virtual neurons (power of 2, >= 2)
//     THRESH      8-bit firing threshold
//     LEAK_SHIFT  right shift applied to the stored state on each update
module lif_tdm_scheduler #(
  parameter int N_NEUR     = 4,
  parameter int THRESH     = 200,
  parameter int LEAK_SHIFT = 1
) (
  input  logic               clk,
  input  logic               rst,
  lif_tdm_scheduler_if.slave bus
);
  localparam int                ID_W     = $clog2(N_NEUR);
  localparam logic [7:0]        THRESH_B = 8'(THRESH);
  localparam logic [N_NEUR-1:0] ONE_LSB  = N_NEUR'(1);

  typedef enum logic [1:0] {IDLE, CALC, WRITE} fsm_t;

  fsm_t              state_q, state_d;
  logic [7:0]        mem [N_NEUR];
  logic [ID_W-1:0]   ptr_q;
  logic [ID_W-1:0]   grant_q;
  logic [7:0]        cur_q;
  logic [7:0]        old_q;
  logic [7:0]        new_q;
  logic              fire_q;
  logic [N_NEUR-1:0] ack_q;
  logic              spike_valid_q;
  logic [ID_W-1:0]   spike_id_q;
  logic [7:0]        state_out_q;

  logic [N_NEUR-1:0] eligible;
  logic              grant_found;
  logic [ID_W-1:0]   grant_idx;
  logic [ID_W-1:0]   cand;
  logic [8:0]        sum9;
  logic [7:0]        sum_sat;
  logic              calc_fire;
  logic [7:0]        calc_new;

  // A neuron acked this cycle is masked so a requester still dropping req
  // is not granted a second time.
  assign eligible = bus.req & ~ack_q;

  // Round-robin search starting at ptr; index arithmetic wraps because
  // N_NEUR is a power of two.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int k = 0; k < N_NEUR; k++) begin
      cand = ptr_q + ID_W'(k);
      if (!grant_found && eligible[cand]) begin
        grant_found = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  // Leak, integrate with saturation at 255, then fire and subtract threshold.
  always_comb begin
    sum9      = {1'b0, (old_q >> LEAK_SHIFT)} + {1'b0, cur_q};
    sum_sat   = sum9[8] ? 8'hFF : sum9[7:0];
    calc_fire = (sum_sat >= THRESH_B);
    calc_new  = calc_fire ? (sum_sat - THRESH_B) : sum_sat;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (grant_found) state_d = CALC;
      CALC:    state_d = WRITE;
      WRITE:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Reset clears everything, which also discards any in-flight update.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N_NEUR; i++) mem[i] <= '0;
      ptr_q         <= '0;
      grant_q       <= '0;
      cur_q         <= '0;
      old_q         <= '0;
      new_q         <= '0;
      fire_q        <= 1'b0;
      ack_q         <= '0;
      spike_valid_q <= 1'b0;
      spike_id_q    <= '0;
      state_out_q   <= '0;
    end else begin
      ack_q         <= '0;
      spike_valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (grant_found) begin
            grant_q <= grant_idx;
            cur_q   <= bus.cur[{grant_idx, 3'b000} +: 8];
            old_q   <= mem[grant_idx];
          end
        end
        CALC: begin
          new_q  <= calc_new;
          fire_q <= calc_fire;
        end
        WRITE: begin
          mem[grant_q]  <= new_q;
          ptr_q         <= grant_q + ID_W'(1);
          ack_q         <= ONE_LSB << grant_q;
          spike_valid_q <= fire_q;
          spike_id_q    <= grant_q;
          state_out_q   <= new_q;
        end
        default: ;
      endcase
    end
  end

  assign bus.ack         = ack_q;
  assign bus.spike_valid = spike_valid_q;
  assign bus.spike_id    = spike_id_q;
  assign bus.state_out   = state_out_q;
  assign bus.busy        = (state_q != IDLE);
endmodule

// File: tb/tb_lif_tdm_scheduler.sv
// tb_lif_tdm_scheduler
//   Self-checking bench for lif_tdm_scheduler: a table of single-neuron
//   updates, hand-written round-robin / hold-through-ack / reset-in-CALC
//   sequences, and a randomized multi-requester phase checked against a
//   behavioural model of the neuron array and round-robin arbitration.
module tb_lif_tdm_scheduler;
  localparam int N_NEUR     = 4;
  localparam int THRESH     = 200;
  localparam int LEAK_SHIFT = 1;
  localparam int RAND_CYCLES = 600;

  typedef struct {
    int idx;
    int cur;
    int exp_state;
    int exp_spike;
  } vec_t;

  logic clk = 1'b0;
  logic rst;

  lif_tdm_scheduler_if #(.N_NEUR(N_NEUR)) bus ();

  lif_tdm_scheduler #(
    .N_NEUR    (N_NEUR),
    .THRESH    (THRESH),
    .LEAK_SHIFT(LEAK_SHIFT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int model_state [N_NEUR];
  int model_ptr;
  vec_t vecs [14];
  logic [N_NEUR-1:0] req_hist [RAND_CYCLES];
  logic [N_NEUR-1:0] ack_hist [RAND_CYCLES];

  // Behavioural neuron update: leak by shift, add current, clamp to 8 bits,
  // fire at or above the threshold.
  function automatic int leakFire(input int s, input int c, output bit fire);
    int sum;
    sum = (s >> LEAK_SHIFT) + c;
    if (sum > 255) sum = 255;
    fire = (sum >= THRESH);
    return fire ? sum - THRESH : sum;
  endfunction

  function automatic void modelReset();
    for (int i = 0; i < N_NEUR; i++) model_state[i] = 0;
    model_ptr = 0;
  endfunction

  // Applies one completed update for neuron g to the model; returns the new state.
  function automatic int modelApply(input int g, input int c, output bit fire);
    int n;
    n = leakFire(model_state[g], c, fire);
    model_state[g] = n;
    model_ptr = (g + 1) % N_NEUR;
    return n;
  endfunction

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic checkIdleOutputs(input string tag);
    checkOutput({tag, "_ack"}, int'(bus.ack), 0);
    checkOutput({tag, "_spike_valid"}, int'(bus.spike_valid), 0);
    checkOutput({tag, "_busy"}, int'(bus.busy), 0);
  endtask

  // Holds reset for two edges; leaves the bench aligned at a negedge.
  task automatic doReset();
    rst = 1'b1;
    bus.req = '0;
    bus.cur = '0;
    @(negedge clk);
    @(negedge clk);
    checkOutput("rst_ack", int'(bus.ack), 0);
    checkOutput("rst_spike_valid", int'(bus.spike_valid), 0);
    checkOutput("rst_spike_id", int'(bus.spike_id), 0);
    checkOutput("rst_state_out", int'(bus.state_out), 0);
    checkOutput("rst_busy", int'(bus.busy), 0);
    rst = 1'b0;
    modelReset();
  endtask

  // One isolated update of neuron idx; expects ack exactly three cycles later.
  task automatic applyStimulus(input int idx, input int c, input int exp_state, input int exp_spike);
    int waited;
    bit fire;
    int unused_new;
    bus.req = '0;
    bus.req[idx] = 1'b1;
    bus.cur[idx*8 +: 8] = 8'(c);
    waited = 0;
    do begin
      @(negedge clk);
      waited++;
    end while (bus.ack == '0 && waited < 10);
    checkOutput("latency", waited, 3);
    checkOutput("ack", int'(bus.ack), 1 << idx);
    checkOutput("spike_id", int'(bus.spike_id), idx);
    checkOutput("state_out", int'(bus.state_out), exp_state);
    checkOutput("spike_valid", int'(bus.spike_valid), exp_spike);
    unused_new = modelApply(idx, c, fire);
    bus.req = '0;
    @(negedge clk);
    checkIdleOutputs("after_ack");
    checkOutput("state_out_hold", int'(bus.state_out), exp_state);
  endtask

  // Main test sequence.
  initial begin
    int waited;
    int gap;
    int exp_new;
    int g;
    int last_ack;
    int rand_acks;
    int pend [N_NEUR];
    bit fire;
    bit saw_ack;
    logic [N_NEUR-1:0] a;
    logic [N_NEUR-1:0] elig;
    logic [N_NEUR-1:0] just_dropped;

    // idx, cur, expected state_out, expected spike
    vecs[0]  = '{0, 100, 100, 0};
    vecs[1]  = '{0, 150,   0, 1};
    vecs[2]  = '{1, 100, 100, 0};
    vecs[3]  = '{1, 255,  55, 1};
    vecs[4]  = '{0, 100, 100, 0};
    vecs[5]  = '{3,   7,   7, 0};
    vecs[6]  = '{3,   7,  10, 0};
    vecs[7]  = '{3,   7,  12, 0};
    vecs[8]  = '{3,   7,  13, 0};
    vecs[9]  = '{3,   7,  13, 0};
    vecs[10] = '{0,   0,  50, 0};
    vecs[11] = '{2, 199, 199, 0};
    vecs[12] = '{2, 100, 199, 0};
    vecs[13] = '{2, 101,   0, 1};

    $display("[TB] start");
    doReset();

    for (int v = 0; v < 14; v++)
      applyStimulus(vecs[v].idx, vecs[v].cur, vecs[v].exp_state, vecs[v].exp_spike);

    // ch2 keeps req high through its ack cycle: exactly one update.
    bus.req = 4'b0100;
    bus.cur[2*8 +: 8] = 8'd20;
    waited = 0;
    do begin
      @(negedge clk);
      waited++;
    end while (bus.ack == '0 && waited < 10);
    exp_new = modelApply(2, 20, fire);
    checkOutput("hold_ack", int'(bus.ack), 4'b0100);
    checkOutput("hold_state_out", int'(bus.state_out), exp_new);
    @(negedge clk);
    checkIdleOutputs("hold_masked");
    bus.req = '0;
    saw_ack = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (bus.ack != '0 || bus.busy) saw_ack = 1'b1;
    end
    checkOutput("hold_no_regrant", int'(saw_ack), 0);

    // Round robin with all four requesters held.
    doReset();
    bus.cur = {4{8'd10}};
    bus.req = 4'b1111;
    for (int n = 0; n < 8; n++) begin
      gap = 0;
      do begin
        @(negedge clk);
        gap++;
      end while (bus.ack == '0 && gap < 10);
      if (n == 7) bus.req = '0;
      exp_new = modelApply(n % N_NEUR, 10, fire);
      checkOutput("rr_gap", gap, 3);
      checkOutput("rr_ack", int'(bus.ack), 1 << (n % N_NEUR));
      checkOutput("rr_state_out", int'(bus.state_out), exp_new);
      checkOutput("rr_spike_valid", int'(bus.spike_valid), int'(fire));
    end
    @(negedge clk);
    checkIdleOutputs("rr_end");

    // Reset while the update of ch0 is in CALC.
    bus.req = 4'b0001;
    bus.cur[0 +: 8] = 8'd50;
    @(negedge clk);
    checkOutput("calc_busy", int'(bus.busy), 1);
    rst = 1'b1;
    bus.req = '0;
    @(negedge clk);
    checkOutput("abort_ack", int'(bus.ack), 0);
    checkOutput("abort_state_out", int'(bus.state_out), 0);
    checkOutput("abort_spike_id", int'(bus.spike_id), 0);
    checkOutput("abort_busy", int'(bus.busy), 0);
    rst = 1'b0;
    modelReset();
    saw_ack = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (bus.ack != '0) saw_ack = 1'b1;
    end
    checkOutput("abort_no_ack", int'(saw_ack), 0);
    applyStimulus(0, 10, 10, 0);

    // Randomized multi-requester traffic checked against the model.
    last_ack = -100;
    rand_acks = 0;
    for (int i = 0; i < N_NEUR; i++) pend[i] = 0;
    for (int n = 0; n < RAND_CYCLES; n++) begin
      a = bus.ack;
      ack_hist[n] = a;
      if (a != '0) begin
        rand_acks++;
        checkOutput("rand_onehot", int'($onehot(a)), 1);
        checkOutput("rand_spacing", int'(n - last_ack >= 3), 1);
        last_ack = n;
        g = -1;
        if (n >= 3) begin
          elig = req_hist[n-3] & ~ack_hist[n-3];
          for (int k = 0; k < N_NEUR; k++)
            if (g < 0 && elig[(model_ptr + k) % N_NEUR]) g = (model_ptr + k) % N_NEUR;
        end
        checkOutput("rand_spike_id", int'(bus.spike_id), g);
        checkOutput("rand_ack", int'(a), (g >= 0) ? (1 << g) : 0);
        if (g >= 0) begin
          exp_new = modelApply(g, int'(bus.cur[g*8 +: 8]), fire);
          checkOutput("rand_state_out", int'(bus.state_out), exp_new);
          checkOutput("rand_spike_valid", int'(bus.spike_valid), int'(fire));
        end
      end else if (bus.spike_valid) begin
        checkOutput("rand_spike_without_ack", 1, 0);
      end
      just_dropped = '0;
      for (int i = 0; i < N_NEUR; i++) begin
        if (bus.req[i]) begin
          pend[i]++;
          if (a[i]) begin
            bus.req[i] = 1'b0;
            just_dropped[i] = 1'b1;
            pend[i] = 0;
          end else if (pend[i] > 20) begin
            checkOutput("rand_starved", i + 100, -1);
            bus.req[i] = 1'b0;
            pend[i] = 0;
          end
        end else if (!just_dropped[i] && $urandom_range(0, 2) == 0) begin
          bus.req[i] = 1'b1;
          bus.cur[i*8 +: 8] = 8'($urandom_range(0, 255));
          pend[i] = 0;
        end
      end
      req_hist[n] = bus.req;
      @(negedge clk);
    end
    checkOutput("rand_activity", int'(rand_acks > 50), 1);
    bus.req = '0;
    repeat (6) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Global guard so the run always ends even if a wait loop misbehaves.
  initial begin
    #2000000;
    $display("[TB] FAIL global_timeout: got timeout, expected completion");
    $fatal(1, "[TB] simulation time limit reached");
  end
endmodule
